mem_traffic_gen: RTL and testbench
==================================

Name: mem_traffic_gen

Overview:
- Upstream request sequencer and checker for the SDRAM memory controller. Drives its we/re/addr/data_in request interface and honours its ready handshake.
- Runs four phases in order. Each phase writes N words, then reads the same N addresses back in the same order.
- Checks every data_out beat against the expected pattern and counts mismatches and timeouts.
- Used as the self-test traffic source on the board and in block-level simulation.

Parameters:
- N_PH0, 1, word count of phase 0 (single fixed address).
- N_PH1, 10, word count of phase 1 (sequential columns within one row).
- N_PH2, 1000, word count of phase 2 (linear addresses crossing rows and banks).
- N_PH3, 1000, word count of phase 3 (pseudo-random addresses from a 22-bit LFSR).
- DATA_XOR, 16'hA5C3, XOR mask for the data pattern.
- LFSR_SEED, 22'h2A5F1, seed for phase 3; must be nonzero.
- RD_TIMEOUT, 64, cycles allowed from read issue to data_out_valid.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts the test when IDLE
- ready  in  1  controller can accept a request
- we  out  1  write request, one-cycle pulse
- re  out  1  read request, one-cycle pulse
- addr  out  22  {bank[1:0], row[11:0], col[7:0]}
- data_in  out  16  write data; valid with we
- data_out  in  16  read data from controller
- data_out_valid  in  1  read data strobe
- phase  out  2  current phase index
- phase_start  out  1  one-cycle pulse at entry to each phase
- busy  out  1  test running
- done  out  1  test complete; sticky until reset or start
- err_count  out  16  mismatches plus timeouts; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high, clock edge only):
  - State = IDLE; all outputs 0.
  - Counters and LFSR cleared; LFSR reloaded with LFSR_SEED.
  - Reset mid-test abandons any in-flight request; a late data_out_valid after reset is ignored.
- Address index i counts 0..N-1 within a phase.
  - addr is combinationally derived from phase and i, registered on output.
  - Phase 0: addr = 0.
  - Phase 1: addr = {2'b00, 12'h001, i[7:0]}.
  - Phase 2: addr = i zero-extended to 22 bits.
  - Phase 3: addr = LFSR state. Polynomial x^22+x^21+1; advances once per accepted request. The LFSR is reloaded with LFSR_SEED at the write-to-read turnaround so reads replay the same address sequence.
- Data pattern: data_in = addr[15:0] ^ addr[21:6] ^ DATA_XOR. The expected read value is the same function of the read address.
- Handshake:
  - A request is a one-cycle pulse of we or re, issued only in a cycle where ready=1. we and re are never high together.
  - After issue, ready is ignored for 1 cycle (GAP). The generator then waits for ready=1 before the next issue.
- States:
  - IDLE -> PH_START on start.
  - PH_START: pulse phase_start, clear i -> WR_ISSUE.
  - WR_ISSUE: when ready, pulse we -> WR_GAP.
  - WR_GAP: i++ -> WR_WAIT.
  - WR_WAIT: when ready and i==N -> RD_SETUP; when ready and i<N -> WR_ISSUE.
  - RD_SETUP: i=0, reload LFSR -> RD_ISSUE.
  - RD_ISSUE: when ready, pulse re, start timeout counter -> RD_WAIT.
  - RD_WAIT, on data_out_valid: compare; on mismatch err_count++; then i++.
    - i==N -> PH_END.
    - else -> RD_ISSUE.
  - RD_WAIT, timeout counter reaching RD_TIMEOUT: err_count++ and treat as a completed read.
  - PH_END: phase==3 -> DONE; else phase++ -> PH_START.
  - DONE: done=1, busy=0; start -> PH_START with phase=0 and err_count cleared.
- busy = 1 in every state except IDLE and DONE.
- start is ignored while busy.
- data_out_valid outside RD_WAIT is ignored and not counted.
- A phase with N=0 goes PH_START -> PH_END directly.
- i is 16 bits; every N must be ≤ 65535, checked by an elaboration assertion.

Decomposition:
- Package mem_test_pkg:
  - state enum.
  - address field widths (BANK_W=2, ROW_W=12, COL_W=8).
  - function data_pattern(addr).
  - LFSR taps constant.
- Sub-module lfsr22: synchronous load and enable, 22-bit Fibonacci LFSR.

Test Plan:
- Reset, then start; controller model returns ready=1 always and echoes written data. Expect 2011 we pulses, then 2011 re pulses in the same order. done=1, err_count=0, phase_start seen 4 times.
- Phase 0 write: expect addr=0, data_in=16'hA5C3. Phase 1 index 3: expect addr=22'h000103.
- Model corrupts read data for phase 1 index 5 (bit 0 flipped). Expect err_count=1 at done; all other beats pass.
- Model withholds data_out_valid for one phase 2 read. Expect err_count increments exactly 64 cycles after that re, and the sequence continues to done.
- ready held low for 20 cycles mid-phase 3. Expect no we/re during the stall, no lost or duplicated address, and phase 3 read addresses equal the write addresses in order.
- Assert reset during phase 2 reads. Expect all outputs 0 on the next cycle, state IDLE. A later start restarts at phase 0 with err_count=0.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types, address geometry and the data-pattern helper for the SDRAM
// self-test traffic generator.
package mem_test_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PH_START = 4'd1,
        S_WR_ISSUE = 4'd2,
        S_WR_GAP   = 4'd3,
        S_WR_WAIT  = 4'd4,
        S_RD_SETUP = 4'd5,
        S_RD_ISSUE = 4'd6,
        S_RD_WAIT  = 4'd7,
        S_PH_END   = 4'd8,
        S_DONE     = 4'd9
    } state_e;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DATA_W = 16;

    // Fibonacci taps for x^22 + x^21 + 1 (state bits 21 and 20)
    localparam logic [ADDR_W-1:0] LFSR_TAPS = 22'h30_0000;

    function automatic logic [DATA_W-1:0] data_pattern(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] xor_mask
    );
        return addr[15:0] ^ addr[21:6] ^ xor_mask;
    endfunction

endpackage

// File: rtl/lfsr22.sv
// 22-bit Fibonacci LFSR with synchronous reload to a fixed seed and an
// advance enable; supplies the pseudo-random address stream.
module lfsr22
    import mem_test_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SEED = 22'h2A5F1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    output logic [ADDR_W-1:0] value
);

    logic [ADDR_W-1:0] state_r;
    logic              feedback_s;

    assign feedback_s = ^(state_r & LFSR_TAPS);
    assign value      = state_r;

    // Shift register; a reload takes priority over an advance
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= SEED;
        end else if (load) begin
            state_r <= SEED;
        end else if (enable) begin
            state_r <= {state_r[ADDR_W-2:0], feedback_s};
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/mem_traffic_gen.sv
// Self-test request sequencer for the SDRAM controller: four write-then-read
// phases, read-data checking, and a saturating error counter.
module mem_traffic_gen
    import mem_test_pkg::*;
#(
    parameter int                N_PH0      = 1,
    parameter int                N_PH1      = 10,
    parameter int                N_PH2      = 1000,
    parameter int                N_PH3      = 1000,
    parameter logic [DATA_W-1:0] DATA_XOR   = 16'hA5C3,
    parameter logic [ADDR_W-1:0] LFSR_SEED  = 22'h2A5F1,
    parameter int                RD_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    output logic              we,
    output logic              re,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_out_valid,
    output logic [1:0]        phase,
    output logic              phase_start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count
);

    if (N_PH0 < 0 || N_PH0 > 65535 || N_PH1 < 0 || N_PH1 > 65535 ||
        N_PH2 < 0 || N_PH2 > 65535 || N_PH3 < 0 || N_PH3 > 65535) begin : g_bad_count
        $error("mem_traffic_gen: every phase word count must lie in 0..65535");
    end
    if (LFSR_SEED == 22'h0 || RD_TIMEOUT < 1 || RD_TIMEOUT > 65535) begin : g_bad_param
        $error("mem_traffic_gen: LFSR_SEED must be nonzero and RD_TIMEOUT in 1..65535");
    end

    localparam logic [15:0] TMO_LIMIT = 16'(RD_TIMEOUT);

    state_e            state_r;
    logic [1:0]        phase_r;
    logic [15:0]       i_r;
    logic [15:0]       tmo_r;
    logic              we_r;
    logic              re_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_in_r;
    logic [DATA_W-1:0] exp_r;
    logic              phase_start_r;
    logic              busy_r;
    logic              done_r;
    logic [15:0]       err_r;

    logic [15:0]       n_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] lfsr_s;
    logic              lfsr_load_s;
    logic              lfsr_en_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    lfsr22 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .load   (lfsr_load_s),
        .enable (lfsr_en_s),
        .value  (lfsr_s)
    );

    // Per-phase word count and request address for the current index
    always_comb begin
        n_s    = 16'(N_PH3);
        addr_s = lfsr_s;
        case (phase_r)
            2'd0: begin
                n_s    = 16'(N_PH0);
                addr_s = 22'h0;
            end
            2'd1: begin
                n_s    = 16'(N_PH1);
                addr_s = {{BANK_W{1'b0}}, 12'h001, i_r[COL_W-1:0]};
            end
            2'd2: begin
                n_s    = 16'(N_PH2);
                addr_s = {6'h00, i_r};
            end
            default: begin
                n_s    = 16'(N_PH3);
                addr_s = lfsr_s;
            end
        endcase
    end

    // LFSR restarts at each phase entry and at the write-to-read turnaround,
    // and steps only on requests actually issued in phase 3
    always_comb begin
        lfsr_load_s = 1'b0;
        lfsr_en_s   = 1'b0;
        if (state_r == S_PH_START || state_r == S_RD_SETUP) begin
            lfsr_load_s = 1'b1;
        end else if ((state_r == S_WR_ISSUE || state_r == S_RD_ISSUE) && ready && phase_r == 2'd3) begin
            lfsr_en_s = 1'b1;
        end else begin
            lfsr_en_s = 1'b0;
        end
    end

    // Sequencer FSM with registered request and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= S_IDLE;
            phase_r       <= 2'd0;
            i_r           <= 16'd0;
            tmo_r         <= 16'd0;
            we_r          <= 1'b0;
            re_r          <= 1'b0;
            addr_r        <= 22'h0;
            data_in_r     <= 16'h0000;
            exp_r         <= 16'h0000;
            phase_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 16'h0000;
        end else begin
            we_r          <= 1'b0;
            re_r          <= 1'b0;
            phase_start_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r <= S_PH_START;
                        phase_r <= 2'd0;
                        err_r   <= 16'h0000;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                S_PH_START: begin
                    phase_start_r <= 1'b1;
                    i_r           <= 16'd0;
                    state_r       <= (n_s == 16'd0) ? S_PH_END : S_WR_ISSUE;
                end
                S_WR_ISSUE: begin
                    if (ready) begin
                        we_r      <= 1'b1;
                        addr_r    <= addr_s;
                        data_in_r <= data_pattern(addr_s, DATA_XOR);
                        state_r   <= S_WR_GAP;
                    end
                end
                S_WR_GAP: begin
                    i_r     <= i_r + 16'd1;
                    state_r <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (ready) begin
                        state_r <= (i_r == n_s) ? S_RD_SETUP : S_WR_ISSUE;
                    end
                end
                S_RD_SETUP: begin
                    i_r     <= 16'd0;
                    state_r <= S_RD_ISSUE;
                end
                S_RD_ISSUE: begin
                    if (ready) begin
                        re_r    <= 1'b1;
                        addr_r  <= addr_s;
                        exp_r   <= data_pattern(addr_s, DATA_XOR);
                        tmo_r   <= 16'd1;
                        state_r <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // A timeout counts as one error and closes the read like a beat
                    if (data_out_valid || tmo_r == TMO_LIMIT) begin
                        if (!data_out_valid || data_out != exp_r) begin
                            err_r <= sat_inc(err_r);
                        end
                        i_r     <= i_r + 16'd1;
                        state_r <= ((i_r + 16'd1) == n_s) ? S_PH_END : S_RD_ISSUE;
                    end else begin
                        tmo_r <= tmo_r + 16'd1;
                    end
                end
                S_PH_END: begin
                    if (phase_r == 2'd3) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        phase_r <= phase_r + 2'd1;
                        state_r <= S_PH_START;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign we          = we_r;
    assign re          = re_r;
    assign addr        = addr_r;
    assign data_in     = data_in_r;
    assign phase       = phase_r;
    assign phase_start = phase_start_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err_count   = err_r;

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Bench for mem_traffic_gen: a randomised-latency controller model with fault
// injection, checked against an address/data sequence built from the rules.
module tb_mem_traffic_gen;

    localparam int          N0    = 1;
    localparam int          N1    = 10;
    localparam int          N2    = 1000;
    localparam int          N3    = 1000;
    localparam int          TOTAL = N0 + N1 + N2 + N3;
    localparam int          TMO   = 64;
    localparam logic [15:0] MASK  = 16'hA5C3;
    localparam logic [21:0] SEED  = 22'h2A5F1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        ready;
    logic        we;
    logic        re;
    logic [21:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [1:0]  phase;
    logic        phase_start;
    logic        busy;
    logic        done;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    // expected sequence, built once from the addressing rules
    logic [21:0] exp_addr_q[$];
    logic [1:0]  exp_phase_q[$];
    int          ph_end[4];

    // observations written only by the controller model
    int          cyc = 0;
    logic [15:0] mem [logic [21:0]];
    logic [21:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [1:0]  wr_phase_q[$];
    logic [21:0] rd_addr_q[$];
    int          rd_wseen_q[$];
    int          err_cyc_q[$];
    int          ps_count = 0;
    int          hs_viol = 0;
    int          withheld_cyc = -1;
    int          late_done = 0;

    // fault controls written only by the test tasks
    bit corrupt_en = 1'b0;
    bit spurious_en = 1'b0;
    int withhold_idx = -1;
    int stall_at = -1;
    int late_req = 0;

    mem_traffic_gen dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .ready          (ready),
        .we             (we),
        .re             (re),
        .addr           (addr),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .phase          (phase),
        .phase_start    (phase_start),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pattern(input logic [21:0] a);
        return a[15:0] ^ a[21:6] ^ MASK;
    endfunction

    // Controller model and bus monitor, evaluated on the falling edge
    initial begin
        int          due_q[$];
        logic [15:0] dat_q[$];
        int          wr_idx;
        int          rd_idx;
        int          stall_left;
        logic [15:0] d;
        logic [15:0] last_err;
        wr_idx = 0; rd_idx = 0; stall_left = 0; last_err = 16'h0000;
        ready = 1'b1; data_out_valid = 1'b0; data_out = 16'h0000;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                due_q.delete(); dat_q.delete(); wr_idx = 0; rd_idx = 0;
            end else begin
                if (phase_start) begin
                    ps_count++; wr_idx = 0; rd_idx = 0;
                end
                if (we) begin
                    if (!ready || re) hs_viol++;
                    wr_addr_q.push_back(addr); wr_data_q.push_back(data_in); wr_phase_q.push_back(phase);
                    mem[addr] = data_in;
                    if (phase == 2'd3 && wr_idx == stall_at) stall_left = 20;
                    wr_idx++;
                end
                if (re) begin
                    if (!ready) hs_viol++;
                    rd_addr_q.push_back(addr); rd_wseen_q.push_back(wr_addr_q.size());
                    if (phase == 2'd2 && rd_idx == withhold_idx) begin
                        withheld_cyc = cyc;
                    end else begin
                        d = mem.exists(addr) ? mem[addr] : 16'h0000;
                        if (corrupt_en && phase == 2'd1 && rd_idx == 5) d = d ^ 16'h0001;
                        due_q.push_back(cyc + int'($urandom_range(0, 3))); dat_q.push_back(d);
                    end
                    rd_idx++;
                end
            end
            if (err_count !== last_err) begin
                err_cyc_q.push_back(cyc); last_err = err_count;
            end
            data_out_valid = 1'b0;
            if (late_req != late_done) begin
                data_out_valid = 1'b1; data_out = 16'hDEAD; late_done++;
            end else if (spurious_en && we && phase == 2'd1) begin
                data_out_valid = 1'b1; data_out = 16'hBEEF;
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                data_out_valid = 1'b1; data_out = dat_q[0];
                void'(due_q.pop_front()); void'(dat_q.pop_front());
            end
            if (stall_left > 0) begin
                ready = 1'b0; stall_left--;
            end else begin
                ready = 1'b1;
            end
        end
    end

    task automatic drive_start;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({we, re, addr, data_in, phase, phase_start, busy, done, err_count} !== 61'd0) begin
            $display("FAIL reset_outputs: got we=%b re=%b addr=%h din=%h ph=%0d ps=%b busy=%b done=%b err=%h, expected all zero",
                     we, re, addr, data_in, phase, phase_start, busy, done, err_count);
            errors++;
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_addr_q.size() != 0) begin
            $display("FAIL idle_without_start: busy=%b done=%b writes=%0d, expected 0 0 0", busy, done, wr_addr_q.size());
            errors++;
        end
    endtask

    task automatic test_faults;
        int wb, rb, eb, hb; bit ok;
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); eb = err_cyc_q.size(); hb = hs_viol;
        corrupt_en = 1'b1;
        withhold_idx = $urandom_range(0, N2 - 1);
        stall_at = $urandom_range(100, N3 - 100);
        drive_start;
        wait_done(40000, ok);
        corrupt_en = 1'b0; withhold_idx = -1; stall_at = -1;
        checks++;
        if (!ok) begin $display("FAIL faults_done: done not reached within budget"); errors++; end
        checks++;
        if (err_count !== 16'd2) begin
            $display("FAIL faults_err_count: got %0d expected 2", err_count); errors++;
        end
        checks++;
        if (err_cyc_q.size() - eb != 2) begin
            $display("FAIL faults_err_steps: got %0d increments expected 2", err_cyc_q.size() - eb); errors++;
        end else if (err_cyc_q[eb + 1] != withheld_cyc + TMO) begin
            $display("FAIL timeout_latency: error at +%0d cycles after re, expected +%0d", err_cyc_q[eb + 1] - withheld_cyc, TMO);
            errors++;
        end
        checks++;
        if (hs_viol != hb) begin
            $display("FAIL stall_handshake: got %0d requests without ready expected 0", hs_viol - hb); errors++;
        end
        checks++;
        if (wr_addr_q.size() - wb != TOTAL || rd_addr_q.size() - rb != TOTAL) begin
            $display("FAIL faults_counts: got %0d writes %0d reads expected %0d each", wr_addr_q.size() - wb, rd_addr_q.size() - rb, TOTAL);
            errors++;
        end
        for (int k = ph_end[2]; k < TOTAL && wb + k < wr_addr_q.size() && rb + k < rd_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wb + k] !== exp_addr_q[k] || rd_addr_q[rb + k] !== exp_addr_q[k]) begin
                $display("FAIL ph3_addr[%0d]: got wr %h rd %h expected %h", k - ph_end[2], wr_addr_q[wb + k], rd_addr_q[rb + k], exp_addr_q[k]);
                errors++;
                break;
            end
        end
    endtask

    task automatic test_clean_run;
        int wb, rb, pb, hb; bit ok;
        wb = wr_addr_q.size(); rb = rd_addr_q.size(); pb = ps_count; hb = hs_viol;
        spurious_en = 1'b1;
        drive_start;
        checks++;
        if (err_count !== 16'h0000 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL restart_from_done: err=%0d busy=%b done=%b expected 0 1 0", err_count, busy, done); errors++;
        end
        repeat (100) @(negedge clock);
        drive_start;
        wait_done(40000, ok);
        spurious_en = 1'b0;
        checks++;
        if (!ok) begin $display("FAIL clean_done: done not reached within budget"); errors++; end
        checks++;
        if (err_count !== 16'h0000) begin $display("FAIL clean_err_count: got %0d expected 0", err_count); errors++; end
        checks++;
        if (ps_count - pb != 4) begin $display("FAIL phase_start_count: got %0d expected 4", ps_count - pb); errors++; end
        checks++;
        if (wr_addr_q.size() - wb != TOTAL || rd_addr_q.size() - rb != TOTAL || hs_viol != hb) begin
            $display("FAIL clean_counts: got %0d writes %0d reads %0d bad handshakes expected %0d %0d 0",
                     wr_addr_q.size() - wb, rd_addr_q.size() - rb, hs_viol - hb, TOTAL, TOTAL);
            errors++;
        end
        checks++;
        if (wr_addr_q[wb] !== 22'h0 || wr_data_q[wb] !== 16'hA5C3) begin
            $display("FAIL ph0_write: got addr %h data %h expected 000000 a5c3", wr_addr_q[wb], wr_data_q[wb]); errors++;
        end
        checks++;
        if (wr_addr_q[wb + 4] !== 22'h000103 || wr_data_q[wb + 4] !== 16'hA4C4) begin
            $display("FAIL ph1_idx3_write: got addr %h data %h expected 000103 a4c4", wr_addr_q[wb + 4], wr_data_q[wb + 4]); errors++;
        end
        for (int k = 0; k < TOTAL && wb + k < wr_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wb + k] !== exp_addr_q[k] || wr_data_q[wb + k] !== pattern(exp_addr_q[k]) ||
                wr_phase_q[wb + k] !== exp_phase_q[k]) begin
                $display("FAIL write[%0d]: got addr %h data %h phase %0d expected %h %h %0d", k, wr_addr_q[wb + k],
                         wr_data_q[wb + k], wr_phase_q[wb + k], exp_addr_q[k], pattern(exp_addr_q[k]), exp_phase_q[k]);
                errors++;
                break;
            end
        end
        for (int k = 0; k < TOTAL && rb + k < rd_addr_q.size(); k++) begin
            checks++;
            if (rd_addr_q[rb + k] !== exp_addr_q[k] || rd_wseen_q[rb + k] != wb + ph_end[exp_phase_q[k]]) begin
                $display("FAIL read[%0d]: got addr %h after %0d writes expected %h after %0d", k, rd_addr_q[rb + k],
                         rd_wseen_q[rb + k] - wb, exp_addr_q[k], ph_end[exp_phase_q[k]]);
                errors++;
                break;
            end
        end
        repeat (5) @(negedge clock);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL done_sticky: done=%b busy=%b expected 1 0", done, busy); errors++;
        end
    endtask

    task automatic test_reset_mid_run;
        int rb, wc, rc, k; bit found;
        rb = rd_addr_q.size();
        k = $urandom_range(1, 50);
        drive_start;
        found = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clock);
            if (rd_addr_q.size() - rb >= N0 + N1 + k) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || phase !== 2'd2) begin
            $display("FAIL reach_ph2_reads: found=%b phase=%0d expected 1 2", found, phase); errors++;
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({we, re, addr, data_in, phase, phase_start, busy, done, err_count} !== 61'd0) begin
            $display("FAIL midrun_reset_outputs: got we=%b re=%b addr=%h din=%h ph=%0d ps=%b busy=%b done=%b err=%h, expected all zero",
                     we, re, addr, data_in, phase, phase_start, busy, done, err_count);
            errors++;
        end
        reset = 1'b0;
        late_req++;
        wc = wr_addr_q.size(); rc = rd_addr_q.size();
        repeat (6) @(negedge clock);
        checks++;
        if (err_count !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || wr_addr_q.size() != wc || rd_addr_q.size() != rc) begin
            $display("FAIL late_valid_ignored: err=%0d busy=%b done=%b new_requests=%0d expected 0 0 0 0",
                     err_count, busy, done, (wr_addr_q.size() - wc) + (rd_addr_q.size() - rc));
            errors++;
        end
    endtask

    task automatic test_restart;
        int wb, pb; bit ok;
        wb = wr_addr_q.size(); pb = ps_count;
        drive_start;
        checks++;
        if (phase !== 2'd0 || busy !== 1'b1 || err_count !== 16'h0000) begin
            $display("FAIL restart_state: phase=%0d busy=%b err=%0d expected 0 1 0", phase, busy, err_count); errors++;
        end
        wait_done(40000, ok);
        checks++;
        if (!ok || err_count !== 16'h0000 || ps_count - pb != 4 || wr_addr_q.size() - wb != TOTAL) begin
            $display("FAIL restart_run: done=%b err=%0d phase_starts=%0d writes=%0d expected 1 0 4 %0d",
                     ok, err_count, ps_count - pb, wr_addr_q.size() - wb, TOTAL);
            errors++;
        end
        checks++;
        if (wr_addr_q[wb] !== 22'h0) begin
            $display("FAIL restart_first_addr: got %h expected 000000", wr_addr_q[wb]); errors++;
        end
    endtask

    initial begin
        logic [21:0] s;
        reset = 1'b1; start = 1'b0;
        ph_end[0] = N0; ph_end[1] = N0 + N1; ph_end[2] = N0 + N1 + N2; ph_end[3] = TOTAL;
        exp_addr_q.push_back(22'h0); exp_phase_q.push_back(2'd0);
        for (int i = 0; i < N1; i++) begin
            exp_addr_q.push_back(22'h000100 + 22'(i)); exp_phase_q.push_back(2'd1);
        end
        for (int i = 0; i < N2; i++) begin
            exp_addr_q.push_back(22'(i)); exp_phase_q.push_back(2'd2);
        end
        s = SEED;
        for (int i = 0; i < N3; i++) begin
            exp_addr_q.push_back(s); exp_phase_q.push_back(2'd3);
            s = {s[20:0], s[21] ^ s[20]};
        end
        test_reset;
        test_faults;
        test_clean_run;
        test_reset_mid_run;
        test_restart;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
